// File: rtl/serdes_pkg.sv
// rtl/serdes_pkg.sv - shared constants, state encoding and word helpers for the serdes receive link controller
package serdes_pkg;

  // Decoded receive word: 8 data bits plus the K flag in bit 8
  localparam int WORD_W = 9;

  // K28.5 comma as presented by the decoder (K flag set, 0xBC)
  localparam logic [WORD_W-1:0] K28_5 = 9'h1BC;

  // Width of the small comma / error-level / good-word counters (limits are 1..15)
  localparam int LVL_W = 4;

  typedef enum logic [1:0] {
    ST_LOS  = 2'd0,
    ST_ACQ  = 2'd1,
    ST_SYNC = 2'd2,
    ST_ERR  = 2'd3
  } link_state_e;

  // A comma only counts toward acquisition when the word itself was received cleanly
  function automatic logic is_comma(input logic [WORD_W-1:0] word, input logic bad);
    return (word == K28_5) && !bad;
  endfunction

endpackage

// File: rtl/serdes_rx_sync_fsm.sv
// rtl/serdes_rx_sync_fsm.sv - word-sync state machine with error leaky bucket and idle realign timer
module serdes_rx_sync_fsm
  import serdes_pkg::*;
#(
  parameter int ACQ_COMMAS   = 3,
  parameter int MAX_ERRS     = 4,
  parameter int GOOD_TO_HEAL = 4,
  parameter int TIMEOUT      = 1023
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       link_en,
  input  logic       word_valid,
  input  logic       word_bad,
  input  logic       word_comma,
  output logic [1:0] state,
  output logic       link_up,
  output logic       rx_enable,
  output logic       rx_realign
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  // Counter values at which the next qualifying event completes the step
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [LVL_W-1:0]  ACQ_LAST  = LVL_W'(ACQ_COMMAS - 1);
  localparam logic [LVL_W-1:0]  MAX_LAST  = LVL_W'(MAX_ERRS - 1);
  localparam logic [LVL_W-1:0]  GTH_LAST  = LVL_W'(GOOD_TO_HEAL - 1);
  localparam logic [LVL_W-1:0]  LVL_ONE   = LVL_W'(1);
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);

  link_state_e       state_q, state_d;
  logic [LVL_W-1:0]  comma_cnt_q, comma_cnt_d;
  logic [LVL_W-1:0]  err_lvl_q, err_lvl_d;
  logic [LVL_W-1:0]  good_cnt_q, good_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              link_up_q, link_up_d;
  logic              rx_enable_q, rx_enable_d;
  logic              rx_realign_q, rx_realign_d;

  // Next-state and counter decisions; word events only act on word_valid cycles
  always_comb begin
    state_d      = state_q;
    comma_cnt_d  = comma_cnt_q;
    err_lvl_d    = err_lvl_q;
    good_cnt_d   = good_cnt_q;
    idle_cnt_d   = '0;
    link_up_d    = link_up_q;
    rx_realign_d = 1'b0;
    rx_enable_d  = link_en;

    if (!link_en) begin
      state_d     = ST_LOS;
      comma_cnt_d = '0;
      err_lvl_d   = '0;
      good_cnt_d  = '0;
      link_up_d   = 1'b0;
    end else begin
      case (state_q)
        ST_LOS: begin
          if (!word_valid) begin
            // Idle timer only runs while hunting; a silent receiver gets periodic realigns
            if (idle_cnt_q == IDLE_LAST) begin
              rx_realign_d = 1'b1;
            end else begin
              idle_cnt_d = idle_cnt_q + IDLE_ONE;
            end
          end else if (word_comma) begin
            if (ACQ_COMMAS == 1) begin
              state_d   = ST_SYNC;
              link_up_d = 1'b1;
            end else begin
              state_d     = ST_ACQ;
              comma_cnt_d = LVL_ONE;
            end
          end
        end

        ST_ACQ: begin
          if (word_valid) begin
            if (word_bad) begin
              state_d      = ST_LOS;
              comma_cnt_d  = '0;
              rx_realign_d = 1'b1;
            end else if (word_comma) begin
              if (comma_cnt_q == ACQ_LAST) begin
                state_d     = ST_SYNC;
                link_up_d   = 1'b1;
                comma_cnt_d = '0;
              end else begin
                comma_cnt_d = comma_cnt_q + LVL_ONE;
              end
            end
          end
        end

        ST_SYNC: begin
          if (word_valid && word_bad) begin
            if (MAX_ERRS == 1) begin
              state_d      = ST_LOS;
              link_up_d    = 1'b0;
              rx_realign_d = 1'b1;
            end else begin
              state_d    = ST_ERR;
              err_lvl_d  = LVL_ONE;
              good_cnt_d = '0;
            end
          end
        end

        ST_ERR: begin
          if (word_valid) begin
            if (word_bad) begin
              good_cnt_d = '0;
              if (err_lvl_q == MAX_LAST) begin
                state_d      = ST_LOS;
                link_up_d    = 1'b0;
                rx_realign_d = 1'b1;
                err_lvl_d    = '0;
              end else begin
                err_lvl_d = err_lvl_q + LVL_ONE;
              end
            end else if (good_cnt_q == GTH_LAST) begin
              // A full run of good words drains one unit of error level
              good_cnt_d = '0;
              err_lvl_d  = err_lvl_q - LVL_ONE;
              if (err_lvl_q == LVL_ONE) begin
                state_d = ST_SYNC;
              end
            end else begin
              good_cnt_d = good_cnt_q + LVL_ONE;
            end
          end
        end

        default: begin
          state_d = ST_LOS;
        end
      endcase
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_LOS;
      comma_cnt_q  <= '0;
      err_lvl_q    <= '0;
      good_cnt_q   <= '0;
      idle_cnt_q   <= '0;
      link_up_q    <= 1'b0;
      rx_enable_q  <= 1'b0;
      rx_realign_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      comma_cnt_q  <= comma_cnt_d;
      err_lvl_q    <= err_lvl_d;
      good_cnt_q   <= good_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      link_up_q    <= link_up_d;
      rx_enable_q  <= rx_enable_d;
      rx_realign_q <= rx_realign_d;
    end
  end

  assign state      = state_q;
  assign link_up    = link_up_q;
  assign rx_enable  = rx_enable_q;
  assign rx_realign = rx_realign_q;

endmodule

// File: rtl/serdes_rx_link_ctrl.sv
// rtl/serdes_rx_link_ctrl.sv - receive link controller top: sync FSM, data gating, bad-word stats (optional COMMA_STRIP_EN)
module serdes_rx_link_ctrl
  import serdes_pkg::*;
#(
  parameter int ACQ_COMMAS   = 3,
  parameter int MAX_ERRS     = 4,
  parameter int GOOD_TO_HEAL = 4,
  parameter int TIMEOUT      = 1023,
  parameter int ERR_CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 link_en,
  input  logic [WORD_W-1:0]    rx_data,
  input  logic                 rx_valid,
  input  logic                 rx_code_err,
  input  logic                 rx_disp_err,
  input  logic                 err_clr,
  output logic                 rx_enable,
  output logic                 rx_realign,
  output logic                 link_up,
  output logic [1:0]           state,
  output logic [WORD_W-1:0]    data_out,
  output logic                 data_valid,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic word_bad;
  logic word_comma;
  logic fwd;

  logic [WORD_W-1:0]    data_out_q, data_out_d;
  logic                 data_valid_q, data_valid_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  assign word_bad   = rx_code_err | rx_disp_err;
  assign word_comma = is_comma(rx_data, word_bad);

  serdes_rx_sync_fsm #(
    .ACQ_COMMAS   (ACQ_COMMAS),
    .MAX_ERRS     (MAX_ERRS),
    .GOOD_TO_HEAL (GOOD_TO_HEAL),
    .TIMEOUT      (TIMEOUT)
  ) u_sync_fsm (
    .clk        (clk),
    .reset_n    (reset_n),
    .link_en    (link_en),
    .word_valid (rx_valid),
    .word_bad   (word_bad),
    .word_comma (word_comma),
    .state      (state),
    .link_up    (link_up),
    .rx_enable  (rx_enable),
    .rx_realign (rx_realign)
  );

  // Forwarding and statistics use link_up as it stood before this word, so the
  // word that completes acquisition is held back and the one that drops sync still counts
  always_comb begin
    fwd = rx_valid & ~word_bad & link_up & link_en;
`ifdef COMMA_STRIP_EN
    if (rx_data == K28_5) begin
      fwd = 1'b0;
    end
`endif
    data_valid_d = fwd;
    data_out_d   = fwd ? rx_data : data_out_q;

    err_count_d = err_count_q;
    if (err_clr) begin
      err_count_d = '0;
    end else if (rx_valid && word_bad && link_up && (err_count_q != '1)) begin
      err_count_d = err_count_q + ERR_CNT_W'(1);
    end
  end

  // Output data and statistics registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      err_count_q  <= err_count_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_serdes_rx_link_ctrl.sv
// tb/tb_serdes_rx_link_ctrl.sv - self-checking bench for serdes_rx_link_ctrl against a behavioural link model
module tb_serdes_rx_link_ctrl;

  localparam int ACQ     = 3;
  localparam int MAXE    = 4;
  localparam int GTH     = 4;
  localparam int TMO     = 1023;
  localparam int CW      = 4;
  localparam int ERR_MAX = 15;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       link_en;
  logic [8:0] rx_data;
  logic       rx_valid;
  logic       rx_code_err;
  logic       rx_disp_err;
  logic       err_clr;
  logic       rx_enable;
  logic       rx_realign;
  logic       link_up;
  logic [1:0] state;
  logic [8:0] data_out;
  logic       data_valid;
  logic [CW-1:0] err_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serdes_rx_link_ctrl #(
    .ACQ_COMMAS(ACQ), .MAX_ERRS(MAXE), .GOOD_TO_HEAL(GTH), .TIMEOUT(TMO), .ERR_CNT_W(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .link_en(link_en), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_code_err(rx_code_err), .rx_disp_err(rx_disp_err),
    .err_clr(err_clr), .rx_enable(rx_enable), .rx_realign(rx_realign),
    .link_up(link_up), .state(state), .data_out(data_out),
    .data_valid(data_valid), .err_count(err_count)
  );

  wire [18:0] obs = {state, link_up, rx_realign, rx_enable, data_valid, data_out, err_count};

  // Behavioural model: link_up is derived from the state, counters are plain ints
  int         m_state, m_commas, m_errs, m_goods, m_idle, m_errcnt;
  logic       m_realign, m_en, m_dval;
  logic [8:0] m_dout;
  logic [18:0] expv;

  function automatic logic m_up();
    return (m_state == 2) || (m_state == 3);
  endfunction

  task automatic model_pack();
    expv = {2'(m_state), m_up(), m_realign, m_en, m_dval, m_dout, 4'(m_errcnt)};
  endtask

  task automatic model_reset();
    m_state = 0; m_commas = 0; m_errs = 0; m_goods = 0; m_idle = 0; m_errcnt = 0;
    m_realign = 0; m_en = 0; m_dval = 0; m_dout = '0;
    model_pack();
  endtask

  task automatic model_lose();
    m_state = 0; m_realign = 1; m_commas = 0; m_errs = 0; m_goods = 0;
  endtask

  task automatic model_step();
    bit bad, comma, was_up;
    if (!reset_n) begin
      model_reset();
      return;
    end
    bad    = rx_code_err | rx_disp_err;
    comma  = (rx_data == 9'h1BC) && !bad;
    was_up = m_up();
    if (err_clr) m_errcnt = 0;
    else if (rx_valid && bad && was_up && m_errcnt < ERR_MAX) m_errcnt++;
    m_dval = rx_valid && !bad && was_up && link_en;
`ifdef COMMA_STRIP_EN
    if (rx_data == 9'h1BC) m_dval = 0;
`endif
    if (m_dval) m_dout = rx_data;
    m_en = link_en;
    m_realign = 0;
    if (!link_en) begin
      m_state = 0; m_commas = 0; m_errs = 0; m_goods = 0; m_idle = 0;
    end else if (m_state == 0) begin
      if (!rx_valid) begin
        m_idle++;
        if (m_idle == TMO) begin
          m_realign = 1;
          m_idle = 0;
        end
      end else begin
        m_idle = 0;
        if (comma) begin
          m_commas = 1;
          m_state = (m_commas >= ACQ) ? 2 : 1;
          if (m_state == 2) m_commas = 0;
        end
      end
    end else begin
      m_idle = 0;
      if (rx_valid) begin
        if (m_state == 1) begin
          if (bad) model_lose();
          else if (comma) begin
            m_commas++;
            if (m_commas == ACQ) begin
              m_state = 2;
              m_commas = 0;
            end
          end
        end else if (bad) begin
          m_errs = (m_state == 2) ? 1 : m_errs + 1;
          m_goods = 0;
          m_state = 3;
          if (m_errs >= MAXE) model_lose();
        end else if (m_state == 3) begin
          m_goods++;
          if (m_goods == GTH) begin
            m_goods = 0;
            m_errs--;
            if (m_errs == 0) m_state = 2;
          end
        end
      end
    end
    model_pack();
  endtask

  task automatic cycle(input logic v, input logic [8:0] d, input logic ce, input logic de);
    rx_valid = v; rx_data = d; rx_code_err = ce; rx_disp_err = de;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    reset_n = 0; link_en = 0; err_clr = 0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      link_en = 1'($urandom);
      cycle(1'($urandom), 9'($urandom), 1'($urandom), 1'($urandom));
      checks++;
      if (obs !== 19'd0) begin
        failures++;
        $display("FAIL reset_outputs got=%h want=%h", obs, 19'd0);
      end
    end
    @(negedge clk);
    reset_n = 1; link_en = 0;
    cycle(0, 9'h0, 0, 0);
  endtask

  task automatic test_acquire();
    link_en = 1;
    cycle(0, 9'h0, 0, 0);
    checks++;
    if (rx_enable !== 1'b1) begin failures++; $display("FAIL rx_enable_on got=%b want=1", rx_enable); end
    for (int i = 0; i < 3; i++) begin
      cycle(1, 9'h1BC, 0, 0);
      checks++;
      if (rx_realign !== 1'b0) begin failures++; $display("FAIL acq_no_realign got=%b want=0", rx_realign); end
      if (i == 0) begin
        checks++;
        if (state !== 2'd1) begin failures++; $display("FAIL acq_state1 got=%0d want=1", state); end
      end
    end
    checks++;
    if (link_up !== 1'b1 || state !== 2'd2 || data_valid !== 1'b0) begin
      failures++;
      $display("FAIL acq_done got=%b/%0d/%b want=1/2/0", link_up, state, data_valid);
    end
    checks++;
    if (obs !== expv) begin failures++; $display("FAIL acq_model got=%h want=%h", obs, expv); end
  endtask

  task automatic test_err_heal();
    cycle(1, 9'h077, 1, 0);
    checks++;
    if (state !== 2'd3 || data_valid !== 1'b0 || link_up !== 1'b1) begin
      failures++;
      $display("FAIL heal_bad got=%0d/%b/%b want=3/0/1", state, data_valid, link_up);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1, 9'h0A0 + 9'(i), 0, 0);
      checks++;
      if (data_valid !== 1'b1 || data_out !== 9'h0A0 + 9'(i) || state !== ((i == 3) ? 2'd2 : 2'd3)) begin
        failures++;
        $display("FAIL heal_good%0d got=%b/%h/%0d want=1/%h/%0d", i, data_valid, data_out, state,
                 9'h0A0 + 9'(i), (i == 3) ? 2 : 3);
      end
    end
    checks++;
    if (err_count !== 4'd1) begin failures++; $display("FAIL heal_errcnt got=%0d want=1", err_count); end
  endtask

  task automatic test_loss();
    err_clr = 1;
    cycle(0, 9'h0, 0, 0);
    err_clr = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1, 9'h1BC, i[0], !i[0]);
      if (i < 3) begin
        checks++;
        if (state !== 2'd3 || rx_realign !== 1'b0) begin
          failures++;
          $display("FAIL loss_bad%0d got=%0d/%b want=3/0", i, state, rx_realign);
        end
      end
    end
    checks++;
    if (state !== 2'd0 || link_up !== 1'b0 || rx_realign !== 1'b1 || err_count !== 4'd4) begin
      failures++;
      $display("FAIL loss_final got=%0d/%b/%b/%0d want=0/0/1/4", state, link_up, rx_realign, err_count);
    end
    cycle(0, 9'h0, 0, 0);
    checks++;
    if (rx_realign !== 1'b0) begin failures++; $display("FAIL loss_pulse_width got=%b want=0", rx_realign); end
  endtask

  task automatic test_timeout();
    int pulses[$];
    // one idle cycle already elapsed at the end of test_loss
    for (int i = 2; i <= 2 * TMO; i++) begin
      cycle(0, 9'($urandom), 1'($urandom), 1'($urandom));
      if (rx_realign) pulses.push_back(i);
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL timeout_model cyc=%0d got=%h want=%h", i, obs, expv); end
    end
    checks++;
    if (pulses.size() != 2 || pulses[0] != TMO || pulses[1] != 2 * TMO) begin
      failures++;
      $display("FAIL timeout_pulses got=%0d pulses first=%0d want=2 first=%0d",
               pulses.size(), (pulses.size() > 0) ? pulses[0] : -1, TMO);
    end
  endtask

  task automatic test_sat_clear();
    for (int i = 0; i < 3; i++) cycle(1, 9'h1BC, 0, 0);
    err_clr = 1;
    cycle(0, 9'h0, 0, 0);
    err_clr = 0;
    for (int r = 0; r < 16; r++) begin
      cycle(1, 9'h033, 0, 1);
      for (int g = 0; g < 4; g++) cycle(1, 9'h055, 0, 0);
    end
    checks++;
    if (err_count !== 4'd15 || state !== 2'd2) begin
      failures++;
      $display("FAIL sat_hold got=%0d/%0d want=15/2", err_count, state);
    end
    err_clr = 1;
    cycle(1, 9'h033, 1, 0);
    err_clr = 0;
    checks++;
    if (err_count !== 4'd0) begin failures++; $display("FAIL clr_priority got=%0d want=0", err_count); end
    checks++;
    if (obs !== expv) begin failures++; $display("FAIL sat_model got=%h want=%h", obs, expv); end
  endtask

  task automatic test_link_disable();
    for (int g = 0; g < 4; g++) cycle(1, 9'h055, 0, 0);
    link_en = 0;
    cycle(1, 9'h1BC, 0, 0);
    checks++;
    if (state !== 2'd0 || link_up !== 1'b0 || rx_enable !== 1'b0 || data_valid !== 1'b0) begin
      failures++;
      $display("FAIL disable got=%0d/%b/%b/%b want=0/0/0/0", state, link_up, rx_enable, data_valid);
    end
    link_en = 1;
    cycle(0, 9'h0, 0, 0);
    checks++;
    if (rx_enable !== 1'b1 || state !== 2'd0) begin
      failures++;
      $display("FAIL reenable got=%b/%0d want=1/0", rx_enable, state);
    end
  endtask

  task automatic test_strip_and_reset();
    logic [8:0] words [3];
    logic       want  [3];
    words[0] = 9'h1BC; words[1] = 9'h055; words[2] = 9'h1BC;
`ifdef COMMA_STRIP_EN
    want[0] = 0; want[1] = 1; want[2] = 0;
`else
    want[0] = 1; want[1] = 1; want[2] = 1;
`endif
    for (int i = 0; i < 3; i++) cycle(1, 9'h1BC, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, words[i], 0, 0);
      checks++;
      if (data_valid !== want[i] || (want[i] && data_out !== words[i])) begin
        failures++;
        $display("FAIL strip_word%0d got=%b/%h want=%b/%h", i, data_valid, data_out, want[i], words[i]);
      end
    end
    cycle(1, 9'h0F0, 1, 0);
    #2;
    reset_n = 0;
    #1;
    checks++;
    if (obs !== 19'd0) begin failures++; $display("FAIL async_reset got=%h want=%h", obs, 19'd0); end
    model_reset();
    cycle(1, 9'h1BC, 0, 0);
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      link_en = ($urandom_range(0, 99) != 0);
      err_clr = ($urandom_range(0, 49) == 0);
      cycle($urandom_range(0, 9) < 7,
            ($urandom_range(0, 1) == 0) ? 9'h1BC : 9'($urandom),
            $urandom_range(0, 24) == 0, $urandom_range(0, 24) == 0);
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL random_model cyc=%0d got=%h want=%h", i, obs, expv); end
    end
    err_clr = 0;
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_err_heal();
    test_loss();
    test_timeout();
    test_sat_clear();
    test_link_disable();
    test_strip_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serdes_rx_link_ctrl.md
Name: serdes_rx_link_ctrl

Overview:
Word-synchronisation controller for the 8b/10b serial receiver.
- Sequences the receiver: enables it, watches its decoded word stream and error flags, declares link up/down, and commands a realign when sync is lost.
- Gates received data to the downstream consumer.
- Sits between the receiver (data, valid, code/disparity error outputs) and the link-layer logic.

Parameters:
ACQ_COMMAS, 3, consecutive error-free K28.5 words needed to declare sync (1..15)
MAX_ERRS, 4, error level at which sync is declared lost (1..15)
GOOD_TO_HEAL, 4, consecutive good words that decrement the error level by one (1..15)
TIMEOUT, 1023, clock cycles without rx_valid, in LOS, before a realign pulse (>=16)
ERR_CNT_W, 16, width of the bad-word statistics counter

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
link_en  in  1  master enable; 0 forces LOS and holds the receiver off
rx_data  in  9  decoded word from receiver; bit8 = K flag, K28.5 = 9'h1BC
rx_valid  in  1  one-cycle strobe per received word
rx_code_err  in  1  code error, qualified by rx_valid
rx_disp_err  in  1  disparity error, qualified by rx_valid
err_clr  in  1  synchronous clear of err_count
rx_enable  out  1  enable to receiver
rx_realign  out  1  one-cycle pulse to reset receiver word alignment
link_up  out  1  sync achieved (SYNC or ERR state)
state  out  2  0=LOS, 1=ACQ, 2=SYNC, 3=ERR
data_out  out  9  forwarded word
data_valid  out  1  forwarded-word strobe
err_count  out  ERR_CNT_W  saturating count of bad words while link_up

Behaviour:
Reset values:
- state=LOS; rx_enable=0; rx_realign=0; link_up=0; data_out=0; data_valid=0; err_count=0; internal counters=0.

Event evaluation:
- All outputs are registered.
- Word events are evaluated only on rx_valid=1; decisions are visible the cycle after the rx_valid cycle.
- bad = rx_code_err | rx_disp_err.
- comma = (rx_data==9'h1BC) & !bad.

link_en=0:
- Next cycle: state=LOS, rx_enable=0, link_up=0, data_valid=0, all counters except err_count cleared.
- rx_enable=1 the cycle after link_en=1.

LOS:
- comma -> comma_cnt=1, go to ACQ.
- Otherwise stay in LOS.
- Idle counter increments on cycles without rx_valid and clears on rx_valid. At TIMEOUT: rx_realign pulses 1 cycle, idle counter clears.

ACQ:
- comma -> comma_cnt++; on reaching ACQ_COMMAS go to SYNC and set link_up=1.
- Good non-comma word -> count held.
- bad -> LOS, comma_cnt=0, rx_realign pulse.
- ACQ_COMMAS=1 goes LOS->SYNC directly on the first comma.

SYNC:
- bad -> ERR, err_lvl=1, good_cnt=0.
- Otherwise stay in SYNC.

ERR:
- bad -> err_lvl++, good_cnt=0. If err_lvl reaches MAX_ERRS: LOS, link_up=0, rx_realign pulse.
- Good word -> good_cnt++. At GOOD_TO_HEAL: err_lvl--, good_cnt=0. If err_lvl becomes 0: SYNC.
- MAX_ERRS=1 goes SYNC->LOS directly on the first bad word.

Forwarding:
- data_out<=rx_data and data_valid<=1 when rx_valid & !bad & link_up (pre-update value).
- Otherwise data_valid=0; data_out holds its value.
- The word that completes acquisition is not forwarded.

err_count:
- Increments on rx_valid & bad & link_up; saturates at all-ones.
- err_clr has priority over a simultaneous increment (result 0).

Reset mid-operation:
- Immediate return to reset values; no realign pulse is emitted.

Optional Feature:
COMMA_STRIP_EN:
- Defined: words equal to 9'h1BC are never forwarded (data_valid stays 0 for them), but they still count as good words for the state machine.
- Undefined: commas are forwarded like any other good word.

Decomposition:
Shared package serdes_pkg:
- state encoding constants LOS/ACQ/SYNC/ERR
- K28_5 9'h1BC constant
- word-width constant 9
Sub-module serdes_rx_sync_fsm:
- state register, comma/err_lvl/good counters, realign and idle-timeout logic.
Top-level serdes_rx_link_ctrl:
- adds forwarding, err_count and the optional strip.

Test Plan:
1. Reset released, link_en=1, 3 clean 9'h1BC valids -> state 1 after first, link_up=1 the cycle after third, rx_realign never pulses.
2. In SYNC, 4 consecutive bad words -> state 3 after first; after fourth state=0, link_up=0, rx_realign high exactly 1 cycle, err_count=4.
3. In SYNC, 1 bad word then 4 good words -> state 3 then back to 2 the cycle after the 4th good word; err_count=1; bad word not forwarded, good words forwarded with data_valid.
4. In LOS, no rx_valid for 1023 cycles -> rx_realign pulse at cycle 1023, then again every 1023 cycles.
5. err_clr asserted in the same cycle as a bad-word increment -> err_count=0; saturation test with ERR_CNT_W=4 holds at 15.
6. COMMA_STRIP_EN defined, SYNC, stream 1BC,055,1BC -> only 055 forwarded; reset_n low mid-stream -> all outputs return to reset values asynchronously.
